writeback_unit: RTL and testbench
=================================

# writeback_unit

Write-back stage of the core: collects completed results from the ALU and the load unit over valid/ready handshakes, arbitrates between them round-robin, and drives the integer register file's single write port one result per cycle. It keeps a pending-write scoreboard so decode can stall on RAW/WAW hazards. Register x0 is never written and never marked pending.

## Interface
- XLEN, 32, data width
- NREGS, 32, architectural registers (index width $clog2(NREGS) = 5)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_reserve_valid  in  1  decode issues an instruction writing i_reserve_index
- i_reserve_index  in  5  destination register being reserved
- i_rs1_index / i_rs2_index  in  5 each  decode source indices
- o_rs1_busy / o_rs2_busy  out  1 each  source has a pending write
- o_rd_busy  out  1  i_reserve_index has a pending write
- i_alu_valid, i_alu_index[5], i_alu_data[XLEN]  in  ALU result
- o_alu_ready  out  1  ALU result accepted this cycle
- i_mem_valid, i_mem_index[5], i_mem_data[XLEN]  in  load result
- o_mem_ready  out  1  load result accepted this cycle
- o_write_enable  out  1  register-file write strobe
- o_write_index  out  5  register-file write index
- o_write_data  out  XLEN  register-file write data
- o_error  out  1  sticky protocol-violation flag

## Operation
- Handshake: transfer when valid && ready at a rising edge; producer holds valid/index/data stable until accepted. Ready is combinational from both valids and the round-robin pointer; no other backpressure (register file always accepts).
- Arbitration: one valid -> granted. Both valid -> grant the source not granted last; last_grant updates only on an actual transfer. After reset last_grant = ALU (load wins first tie).
- Output stage: accepted result registered into o_write_index/o_write_data; o_write_enable = 1 for exactly one cycle unless index is 0 (accepted, enable 0).
- Scoreboard: pending[NREGS-1:1].
  - Set pending[i] at the edge where i_reserve_valid && i != 0 && !pending[i].
  - Clear pending[i] at the edge ending the cycle in which o_write_enable && o_write_index == i (same edge the register file updates).
  - Busy outputs = pending[index] (registered state only; index 0 -> 0). Busy stays high during the write cycle.
- Errors (set o_error, sticky until rst): reserve of a register already pending (reservation ignored, pending unchanged); accepted result with nonzero index whose pending bit is 0 (write still performed).
- Decode must stall while o_rd_busy or any needed rsN_busy.

## Timing
- Reset values: o_write_enable 0, o_write_index 0, o_write_data 0, o_error 0, all pending 0, readies 0 while rst high, busy outputs 0.
- Latency: result accepted at edge N -> o_write_enable high cycle N..N+1 -> register file and scoreboard update at edge N+1. Source read in cycle N+1 onward sees new value only after edge N+1.
- Throughput: one result per cycle sustained; both valid continuously -> strict alternation.
- Reserve and clear of same register in the same cycle: pending still set, so reserve is an error; decode sees o_rd_busy and stalls one cycle.
- Reserve and accept of result for the same register in the same cycle: result clears the earlier reservation one cycle later; new reservation is an error (pending set).
- rst mid-operation: in-flight output write dropped (enable 0 next cycle), scoreboard cleared.

## Structure
- Shared package core_pkg: XLEN, NREGS, REG_INDEX_W, typedefs word_t and reg_index_t.
- Sub-module wb_scoreboard: pending bits, set/clear, three busy lookups, error detection. Arbiter and output register live in writeback_unit.

## Test plan
- Reserve x5, ALU result (x5, 0xDEADBEEF) accepted edge N -> o_write_enable cycle N+1 with index 5, data 0xDEADBEEF; o_rs1_busy for x5 high through cycle N+1, low at N+2.
- Both valid for 4 cycles after reset (mem x3..x6, alu x7..x10) -> grants mem, alu, mem, alu; writes x3, x7, x4, x8 in order.
- ALU result to x0 with valid -> o_alu_ready 1, o_write_enable stays 0, o_error stays 0.
- Reserve x9 twice before write -> o_error 1 after second edge, pending x9 unchanged, single write clears it.
- Result to x12 never reserved -> write performed, o_error 1 and sticky until rst.
- Assert rst during the write cycle of x4 -> next cycle o_write_enable 0, all busy 0, o_error 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: data width, register-file geometry and write-back source encoding.
package core_pkg;
  localparam int XLEN        = 32;
  localparam int NREGS       = 32;
  localparam int REG_INDEX_W = $clog2(NREGS);

  typedef logic [XLEN-1:0]        word_t;
  typedef logic [REG_INDEX_W-1:0] reg_index_t;

  // Identifies which producer won the last write-back transfer.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register (x0 never pending),
// busy lookups for decode and sticky protocol-error detection.
module wb_scoreboard
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       reserve_valid,
  input  reg_index_t reserve_index,
  input  reg_index_t rs1_index,
  input  reg_index_t rs2_index,
  input  logic       clear_valid,
  input  reg_index_t clear_index,
  input  logic       accept_valid,
  input  reg_index_t accept_index,
  output logic       rs1_busy,
  output logic       rs2_busy,
  output logic       rd_busy,
  output logic       error
);

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_next;
  logic             reserve_err;
  logic             accept_err;

  function automatic logic lookup(input logic [NREGS-1:0] p, input reg_index_t idx);
    return (idx != '0) && p[idx];
  endfunction

  assign rs1_busy = lookup(pending, rs1_index);
  assign rs2_busy = lookup(pending, rs2_index);
  assign rd_busy  = lookup(pending, reserve_index);

  assign reserve_err = reserve_valid && lookup(pending, reserve_index);
  assign accept_err  = accept_valid && (accept_index != '0) && !pending[accept_index];

  // Clear first, then set: a reserve only sets when the old bit was clear, so the
  // two can only overlap for an unreserved write, where the new reservation must win.
  always_comb begin
    pending_next = pending;
    if (clear_valid) begin
      pending_next[clear_index] = 1'b0;
    end
    if (reserve_valid && (reserve_index != '0) && !pending[reserve_index]) begin
      pending_next[reserve_index] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      error   <= 1'b0;
    end else begin
      pending <= pending_next;
      if (reserve_err || accept_err) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: round-robin arbitration between ALU and load results, one
// registered register-file write per cycle, and a pending-write scoreboard for decode.
module writeback_unit
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_reserve_valid,
  input  reg_index_t i_reserve_index,
  input  reg_index_t i_rs1_index,
  input  reg_index_t i_rs2_index,
  output logic       o_rs1_busy,
  output logic       o_rs2_busy,
  output logic       o_rd_busy,
  input  logic       i_alu_valid,
  input  reg_index_t i_alu_index,
  input  word_t      i_alu_data,
  output logic       o_alu_ready,
  input  logic       i_mem_valid,
  input  reg_index_t i_mem_index,
  input  word_t      i_mem_data,
  output logic       o_mem_ready,
  output logic       o_write_enable,
  output reg_index_t o_write_index,
  output word_t      o_write_data,
  output logic       o_error
);

  // Handshake: a result transfers at a rising edge where valid && ready; the
  // producer holds valid/index/data stable until then. Ready depends only on
  // both valids and last_grant, since the register file never backpressures.
  wb_src_t    last_grant;
  logic       accept_valid;
  reg_index_t accept_index;
  word_t      accept_data;

  always_comb begin
    o_mem_ready = !rst && i_mem_valid && (!i_alu_valid || (last_grant == SRC_ALU));
    o_alu_ready = !rst && i_alu_valid && (!i_mem_valid || (last_grant == SRC_MEM));
  end

  assign accept_valid = o_alu_ready || o_mem_ready;
  assign accept_index = o_mem_ready ? i_mem_index : i_alu_index;
  assign accept_data  = o_mem_ready ? i_mem_data  : i_alu_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_write_enable <= 1'b0;
      o_write_index  <= '0;
      o_write_data   <= '0;
      last_grant     <= SRC_ALU;
    end else begin
      // x0 results are consumed but never reach the register file.
      o_write_enable <= accept_valid && (accept_index != '0);
      if (accept_valid) begin
        o_write_index <= accept_index;
        o_write_data  <= accept_data;
        last_grant    <= o_mem_ready ? SRC_MEM : SRC_ALU;
      end
    end
  end

  wb_scoreboard u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .reserve_valid (i_reserve_valid),
    .reserve_index (i_reserve_index),
    .rs1_index     (i_rs1_index),
    .rs2_index     (i_rs2_index),
    .clear_valid   (o_write_enable),
    .clear_index   (o_write_index),
    .accept_valid  (accept_valid),
    .accept_index  (accept_index),
    .rs1_busy      (o_rs1_busy),
    .rs2_busy      (o_rs2_busy),
    .rd_busy       (o_rd_busy),
    .error         (o_error)
  );

endmodule

// File: tb/tb_writeback_unit.sv
// Directed scenarios plus randomized traffic against a behavioural write-back model.
module tb_writeback_unit;
  import core_pkg::*;

  logic       clk;
  logic       rst;
  logic       i_reserve_valid;
  reg_index_t i_reserve_index;
  reg_index_t i_rs1_index;
  reg_index_t i_rs2_index;
  logic       o_rs1_busy;
  logic       o_rs2_busy;
  logic       o_rd_busy;
  logic       i_alu_valid;
  reg_index_t i_alu_index;
  word_t      i_alu_data;
  logic       o_alu_ready;
  logic       i_mem_valid;
  reg_index_t i_mem_index;
  word_t      i_mem_data;
  logic       o_mem_ready;
  logic       o_write_enable;
  reg_index_t o_write_index;
  word_t      o_write_data;
  logic       o_error;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit [NREGS-1:0] m_pending;
  bit             m_last_mem;
  bit             m_we;
  reg_index_t     m_widx;
  bit             m_err;
  bit             acc_alu;
  bit             acc_mem;
  logic [REG_INDEX_W+XLEN-1:0] exp_q[$];

  writeback_unit dut (
    .clk             (clk),
    .rst             (rst),
    .i_reserve_valid (i_reserve_valid),
    .i_reserve_index (i_reserve_index),
    .i_rs1_index     (i_rs1_index),
    .i_rs2_index     (i_rs2_index),
    .o_rs1_busy      (o_rs1_busy),
    .o_rs2_busy      (o_rs2_busy),
    .o_rd_busy       (o_rd_busy),
    .i_alu_valid     (i_alu_valid),
    .i_alu_index     (i_alu_index),
    .i_alu_data      (i_alu_data),
    .o_alu_ready     (o_alu_ready),
    .i_mem_valid     (i_mem_valid),
    .i_mem_index     (i_mem_index),
    .i_mem_data      (i_mem_data),
    .o_mem_ready     (o_mem_ready),
    .o_write_enable  (o_write_enable),
    .o_write_index   (o_write_index),
    .o_write_data    (o_write_data),
    .o_error         (o_error)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge: advance the model from the inputs held across the edge.
  task automatic tick();
    bit [NREGS-1:0] next_p;
    reg_index_t     a_idx;
    word_t          a_data;
    @(posedge clk);
    if (rst) begin
      m_pending  = '0;
      m_last_mem = 1'b0;
      m_we       = 1'b0;
      m_widx     = '0;
      m_err      = 1'b0;
      acc_alu    = 1'b0;
      acc_mem    = 1'b0;
      exp_q.delete();
    end else begin
      acc_mem = i_mem_valid && (!i_alu_valid || !m_last_mem);
      acc_alu = i_alu_valid && !acc_mem;
      next_p  = m_pending;
      if (m_we) next_p[m_widx] = 1'b0;
      if (i_reserve_valid && i_reserve_index != 0) begin
        if (m_pending[i_reserve_index]) m_err = 1'b1;
        else next_p[i_reserve_index] = 1'b1;
      end
      m_we = 1'b0;
      if (acc_alu || acc_mem) begin
        a_idx  = acc_mem ? i_mem_index : i_alu_index;
        a_data = acc_mem ? i_mem_data : i_alu_data;
        if (a_idx != 0 && !m_pending[a_idx]) m_err = 1'b1;
        if (a_idx != 0) exp_q.push_back({a_idx, a_data});
        m_last_mem = acc_mem;
        m_we       = (a_idx != 0);
        m_widx     = a_idx;
      end
      m_pending = next_p;
    end
    #1;
  endtask

  // Driver tasks
  task automatic idle_inputs();
    i_reserve_valid = 1'b0;
    i_reserve_index = '0;
    i_rs1_index     = '0;
    i_rs2_index     = '0;
    i_alu_valid     = 1'b0;
    i_alu_index     = '0;
    i_alu_data      = '0;
    i_mem_valid     = 1'b0;
    i_mem_index     = '0;
    i_mem_data      = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic reserve(input reg_index_t idx);
    i_reserve_valid = 1'b1;
    i_reserve_index = idx;
    tick();
    i_reserve_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    i_rs1_index = 5'd1; i_rs2_index = 5'd2; i_reserve_index = 5'd3;
    i_alu_valid = 1'b1; i_mem_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_alu_ready !== 1'b0 || o_mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready got=%b%b exp=00", o_alu_ready, o_mem_ready);
    end
    tick();
    rst = 1'b0; idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({o_write_enable, o_write_index, o_write_data, o_error} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got we=%b idx=%0d data=%h err=%b exp=0",
                         o_write_enable, o_write_index, o_write_data, o_error);
    end
    n_checks++;
    if ({o_rs1_busy, o_rs2_busy, o_rd_busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_busy got=%b%b%b exp=000", o_rs1_busy, o_rs2_busy, o_rd_busy);
    end
    tick();
  endtask

  task automatic test_basic_write();
    do_reset();
    reserve(5'd5);
    i_rs1_index = 5'd5;
    i_alu_valid = 1'b1; i_alu_index = 5'd5; i_alu_data = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if (o_alu_ready !== 1'b1 || o_rs1_busy !== 1'b1 || o_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL basic_accept got rdy=%b busy=%b we=%b exp=1 1 0",
                         o_alu_ready, o_rs1_busy, o_write_enable);
    end
    tick();
    i_alu_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_write_enable !== 1'b1 || o_write_index !== 5'd5 || o_write_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL basic_write got we=%b idx=%0d data=%h exp=1 5 deadbeef",
                         o_write_enable, o_write_index, o_write_data);
    end
    n_checks++;
    if (o_rs1_busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy_during_write got=%b exp=1", o_rs1_busy);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (o_rs1_busy !== 1'b0 || o_write_enable !== 1'b0 || o_error !== 1'b0) begin
      n_fail++; $display("FAIL basic_after got busy=%b we=%b err=%b exp=0 0 0",
                         o_rs1_busy, o_write_enable, o_error);
    end
    tick();
  endtask

  task automatic test_arbitration();
    reg_index_t exp_idx[4];
    reg_index_t mi;
    reg_index_t ai;
    word_t      exp_data;
    exp_idx[0] = 5'd3; exp_idx[1] = 5'd7; exp_idx[2] = 5'd4; exp_idx[3] = 5'd8;
    do_reset();
    for (int r = 3; r <= 10; r++) reserve(5'(r));
    mi = 5'd3; ai = 5'd7;
    for (int k = 0; k <= 4; k++) begin
      i_mem_valid = (k < 4); i_alu_valid = (k < 4);
      i_mem_index = mi; i_mem_data = 32'h1000_0000 + 32'(mi);
      i_alu_index = ai; i_alu_data = 32'h2000_0000 + 32'(ai);
      @(negedge clk);
      if (k < 4) begin
        n_checks++;
        if (o_mem_ready !== ((k % 2) == 0) || o_alu_ready !== ((k % 2) == 1)) begin
          n_fail++; $display("FAIL arb_grant k=%0d got mem=%b alu=%b exp mem=%b",
                             k, o_mem_ready, o_alu_ready, (k % 2) == 0);
        end
      end
      if (k >= 1) begin
        exp_data = (exp_idx[k-1] < 7) ? 32'h1000_0000 + 32'(exp_idx[k-1])
                                      : 32'h2000_0000 + 32'(exp_idx[k-1]);
        n_checks++;
        if (o_write_enable !== 1'b1 || o_write_index !== exp_idx[k-1] || o_write_data !== exp_data) begin
          n_fail++; $display("FAIL arb_write k=%0d got we=%b idx=%0d data=%h exp idx=%0d data=%h",
                             k, o_write_enable, o_write_index, o_write_data, exp_idx[k-1], exp_data);
        end
      end
      tick();
      if (k < 4) begin
        if ((k % 2) == 0) mi = mi + 5'd1;
        else ai = ai + 5'd1;
      end
    end
    idle_inputs();
  endtask

  task automatic test_x0_write();
    do_reset();
    i_alu_valid = 1'b1; i_alu_index = 5'd0; i_alu_data = 32'h1234_5678;
    @(negedge clk);
    n_checks++;
    if (o_alu_ready !== 1'b1) begin
      n_fail++; $display("FAIL x0_ready got=%b exp=1", o_alu_ready);
    end
    tick();
    i_alu_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_write_enable !== 1'b0 || o_error !== 1'b0) begin
      n_fail++; $display("FAIL x0_write got we=%b err=%b exp=0 0", o_write_enable, o_error);
    end
    tick();
  endtask

  task automatic test_double_reserve();
    do_reset();
    reserve(5'd9);
    i_reserve_valid = 1'b1; i_reserve_index = 5'd9;
    @(negedge clk);
    n_checks++;
    if (o_rd_busy !== 1'b1 || o_error !== 1'b0) begin
      n_fail++; $display("FAIL dbl_rd_busy got busy=%b err=%b exp=1 0", o_rd_busy, o_error);
    end
    tick();
    i_reserve_valid = 1'b0; i_rs1_index = 5'd9;
    i_alu_valid = 1'b1; i_alu_index = 5'd9; i_alu_data = 32'h0000_0099;
    @(negedge clk);
    n_checks++;
    if (o_error !== 1'b1 || o_rs1_busy !== 1'b1) begin
      n_fail++; $display("FAIL dbl_error got err=%b busy=%b exp=1 1", o_error, o_rs1_busy);
    end
    tick();
    i_alu_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_write_enable !== 1'b1 || o_write_index !== 5'd9) begin
      n_fail++; $display("FAIL dbl_write got we=%b idx=%0d exp=1 9", o_write_enable, o_write_index);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (o_rs1_busy !== 1'b0) begin
      n_fail++; $display("FAIL dbl_cleared got=%b exp=0", o_rs1_busy);
    end
    tick();
  endtask

  task automatic test_unreserved();
    do_reset();
    i_alu_valid = 1'b1; i_alu_index = 5'd12; i_alu_data = 32'hCAFE_0012;
    tick();
    i_alu_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_write_enable !== 1'b1 || o_write_index !== 5'd12 || o_write_data !== 32'hCAFE_0012 || o_error !== 1'b1) begin
      n_fail++; $display("FAIL unres_write got we=%b idx=%0d data=%h err=%b exp=1 12 cafe0012 1",
                         o_write_enable, o_write_index, o_write_data, o_error);
    end
    for (int c = 0; c < 4; c++) tick();
    @(negedge clk);
    n_checks++;
    if (o_error !== 1'b1) begin
      n_fail++; $display("FAIL unres_sticky got=%b exp=1", o_error);
    end
    do_reset();
    @(negedge clk);
    n_checks++;
    if (o_error !== 1'b0) begin
      n_fail++; $display("FAIL unres_cleared got=%b exp=0", o_error);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    reserve(5'd4);
    reserve(5'd6);
    i_rs1_index = 5'd4; i_rs2_index = 5'd6; i_reserve_index = 5'd6;
    i_alu_valid = 1'b1; i_alu_index = 5'd4; i_alu_data = 32'h4444_4444;
    tick();
    i_alu_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_write_enable !== 1'b1 || o_write_index !== 5'd4) begin
      n_fail++; $display("FAIL mid_write got we=%b idx=%0d exp=1 4", o_write_enable, o_write_index);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_write_enable !== 1'b0 || {o_rs1_busy, o_rs2_busy, o_rd_busy} !== 3'b000 || o_error !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got we=%b busy=%b%b%b err=%b exp=0 000 0",
                         o_write_enable, o_rs1_busy, o_rs2_busy, o_rd_busy, o_error);
    end
    tick();
  endtask

  task automatic test_random();
    logic [REG_INDEX_W+XLEN-1:0] exp_w;
    bit e_alu_rdy;
    bit e_mem_rdy;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst             = ((c % 150) == 149);
      i_reserve_valid = ($urandom_range(0, 2) == 0);
      i_reserve_index = 5'($urandom_range(0, 15));
      i_rs1_index     = 5'($urandom_range(0, 15));
      i_rs2_index     = 5'($urandom_range(0, 15));
      if (!i_alu_valid && $urandom_range(0, 1) == 1) begin
        i_alu_valid = 1'b1; i_alu_index = 5'($urandom_range(0, 15)); i_alu_data = $urandom;
      end
      if (!i_mem_valid && $urandom_range(0, 1) == 1) begin
        i_mem_valid = 1'b1; i_mem_index = 5'($urandom_range(0, 15)); i_mem_data = $urandom;
      end
      e_mem_rdy = !rst && i_mem_valid && (!i_alu_valid || !m_last_mem);
      e_alu_rdy = !rst && i_alu_valid && !(i_mem_valid && !m_last_mem);
      @(negedge clk);
      n_checks++;
      if (o_alu_ready !== e_alu_rdy || o_mem_ready !== e_mem_rdy) begin
        n_fail++; $display("FAIL rnd_ready c=%0d got alu=%b mem=%b exp alu=%b mem=%b",
                           c, o_alu_ready, o_mem_ready, e_alu_rdy, e_mem_rdy);
      end
      n_checks++;
      if (o_rs1_busy !== (i_rs1_index != 0 && m_pending[i_rs1_index]) ||
          o_rs2_busy !== (i_rs2_index != 0 && m_pending[i_rs2_index]) ||
          o_rd_busy  !== (i_reserve_index != 0 && m_pending[i_reserve_index])) begin
        n_fail++; $display("FAIL rnd_busy c=%0d got=%b%b%b pending=%h", c,
                           o_rs1_busy, o_rs2_busy, o_rd_busy, m_pending);
      end
      n_checks++;
      if (o_error !== m_err || o_write_enable !== m_we) begin
        n_fail++; $display("FAIL rnd_status c=%0d got err=%b we=%b exp err=%b we=%b",
                           c, o_error, o_write_enable, m_err, m_we);
      end
      if (m_we) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_checks++;
        if ({o_write_index, o_write_data} !== exp_w) begin
          n_fail++; $display("FAIL rnd_write c=%0d got idx=%0d data=%h exp idx=%0d data=%h",
                             c, o_write_index, o_write_data, exp_w[XLEN +: REG_INDEX_W], exp_w[XLEN-1:0]);
        end
      end
      tick();
      if (acc_alu) i_alu_valid = 1'b0;
      if (acc_mem) i_mem_valid = 1'b0;
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_write();
    test_arbitration();
    test_x0_write();
    test_double_reserve();
    test_unreserved();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
